// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path: FSM states, RAM sizing
// defaults and the RGB565 field layout.
package cam_capture_pkg;

   typedef enum logic {
      S_WAIT_FRAME = 1'b0,
      S_FRAME      = 1'b1
   } cap_state_t;

   // Defaults shared with ram_rgb_write; A_MAX must stay 2**ADD_WIDTH
   localparam int ADD_WIDTH_DEF = 4;
   localparam int A_MAX_DEF     = 16;

   localparam int R_HI = 15;
   localparam int R_LO = 11;
   localparam int G_HI = 10;
   localparam int G_LO = 5;
   localparam int B_HI = 4;
   localparam int B_LO = 0;

endpackage

// File: rtl/rgb565_to_rgb888.sv
// Combinational RGB565 to RGB888 expansion by MSB replication, so full-scale
// 5/6-bit values map to 0xFF and zero stays zero.
module rgb565_to_rgb888
   import cam_capture_pkg::*;
(
   input  logic [15:0] pixel,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue
);

   logic [4:0] r5;
   logic [5:0] g6;
   logic [4:0] b5;

   assign r5 = pixel[R_HI:R_LO];
   assign g6 = pixel[G_HI:G_LO];
   assign b5 = pixel[B_HI:B_LO];

   assign red   = {r5, r5[4:2]};
   assign green = {g6, g6[5:4]};
   assign blue  = {b5, b5[4:2]};

endmodule

// File: rtl/cam_rgb_capture.sv
// Camera front-end: frames an RGB565 byte stream on vsync/href, pairs bytes
// into pixels and issues RGB888 writes to the frame RAM with overflow guard.
module cam_rgb_capture
   import cam_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADD_WIDTH  = ADD_WIDTH_DEF,
   parameter int A_MAX      = A_MAX_DEF
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  byte_en,
   input  logic                  vsync,
   input  logic                  href,
   input  logic [7:0]            cam_data,
   output logic [ADD_WIDTH-1:0]  address_write,
   output logic [DATA_WIDTH-1:0] data_w_R,
   output logic [DATA_WIDTH-1:0] data_w_G,
   output logic [DATA_WIDTH-1:0] data_w_B,
   output logic                  write_enable,
   output logic                  frame_done,
   output logic                  overflow
);

   localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(A_MAX - 1);

   cap_state_t           state;
   cap_state_t           state_next;
   logic                 vsync_q;
   logic                 vsync_fall;
   logic                 vsync_rise;
   logic                 phase;
   logic [7:0]           hi_byte;
   logic [ADD_WIDTH-1:0] addr_cnt;
   logic                 full;

   logic                 frame_start;
   logic                 frame_end;
   logic                 take_hi;
   logic                 take_lo;
   logic                 drop_half;

   logic [7:0]           pix_r;
   logic [7:0]           pix_g;
   logic [7:0]           pix_b;

   assign vsync_fall = vsync_q & ~vsync;
   assign vsync_rise = ~vsync_q & vsync;

   rgb565_to_rgb888 u_expand (
      .pixel (({hi_byte, cam_data})),
      .red   (pix_r),
      .green (pix_g),
      .blue  (pix_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_WAIT_FRAME;
      end else begin
         state <= state_next;
      end
   end

   // vsync rise is checked before any byte so it wins over a completing pixel
   always_comb begin
      state_next  = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      take_hi     = 1'b0;
      take_lo     = 1'b0;
      drop_half   = 1'b0;
      case (state)
         S_WAIT_FRAME: begin
            if (vsync_fall) begin
               state_next  = S_FRAME;
               frame_start = 1'b1;
            end
         end
         S_FRAME: begin
            if (vsync_rise) begin
               state_next = S_WAIT_FRAME;
               frame_end  = 1'b1;
            end else if (byte_en) begin
               if (!href) begin
                  drop_half = 1'b1;
               end else if (!phase) begin
                  take_hi = 1'b1;
               end else begin
                  take_lo = 1'b1;
               end
            end
         end
         default: state_next = S_WAIT_FRAME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q       <= 1'b0;
         phase         <= 1'b0;
         hi_byte       <= '0;
         addr_cnt      <= '0;
         full          <= 1'b0;
         address_write <= '0;
         data_w_R      <= '0;
         data_w_G      <= '0;
         data_w_B      <= '0;
         write_enable  <= 1'b0;
         frame_done    <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         write_enable <= 1'b0;
         frame_done   <= frame_end;
         if (frame_start) begin
            addr_cnt <= '0;
            phase    <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
         end
         if (frame_end || drop_half) begin
            phase <= 1'b0;
         end
         if (take_hi) begin
            hi_byte <= cam_data;
            phase   <= 1'b1;
         end
         // Once the last location is written the counter parks and later pixels are dropped
         if (take_lo) begin
            phase <= 1'b0;
            if (full) begin
               overflow <= 1'b1;
            end else begin
               write_enable  <= 1'b1;
               address_write <= addr_cnt;
               data_w_R      <= DATA_WIDTH'(pix_r);
               data_w_G      <= DATA_WIDTH'(pix_g);
               data_w_B      <= DATA_WIDTH'(pix_b);
               if (addr_cnt == LAST_ADDR) begin
                  full <= 1'b1;
               end else begin
                  addr_cnt <= addr_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_rgb_capture.sv
// Scoreboard bench for cam_rgb_capture: directed pixels push expected writes,
// a negedge monitor pops and compares each write_enable cycle.
module tb_cam_rgb_capture;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_write_t;

   logic       clk;
   logic       rst;
   logic       byte_en;
   logic       vsync;
   logic       href;
   logic [7:0] cam_data;
   logic [3:0] address_write;
   logic [7:0] data_w_R;
   logic [7:0] data_w_G;
   logic [7:0] data_w_B;
   logic       write_enable;
   logic       frame_done;
   logic       overflow;

   exp_write_t sb_queue[$];
   int         compare_count  = 0;
   int         mismatch_count = 0;
   int         frame_done_seen = 0;
   int         frame_done_exp  = 0;

   cam_rgb_capture #(
      .DATA_WIDTH (8),
      .ADD_WIDTH  (4),
      .A_MAX      (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .byte_en       (byte_en),
      .vsync         (vsync),
      .href          (href),
      .cam_data      (cam_data),
      .address_write (address_write),
      .data_w_R      (data_w_R),
      .data_w_G      (data_w_G),
      .data_w_B      (data_w_B),
      .write_enable  (write_enable),
      .frame_done    (frame_done),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (write_enable) begin
         compare_count++;
         if (sb_queue.size() == 0) begin
            mismatch_count++;
            $display("[TB] FAIL unexpected_write: got addr=%0d R=%02h G=%02h B=%02h, expected no write",
                     address_write, data_w_R, data_w_G, data_w_B);
         end else begin
            exp_write_t e;
            e = sb_queue.pop_front();
            if (address_write !== e.addr || data_w_R !== e.r || data_w_G !== e.g || data_w_B !== e.b) begin
               mismatch_count++;
               $display("[TB] FAIL pixel_write: got addr=%0d R=%02h G=%02h B=%02h, expected addr=%0d R=%02h G=%02h B=%02h",
                        address_write, data_w_R, data_w_G, data_w_B, e.addr, e.r, e.g, e.b);
            end
         end
      end
      if (frame_done) frame_done_seen++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compare_count++;
      if (actual !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One byte strobe followed by one idle cycle; called just after a posedge
   task automatic applyStimulus(input logic [7:0] data, input logic line_valid);
      byte_en  = 1'b1;
      cam_data = data;
      href     = line_valid;
      @(posedge clk); #1;
      byte_en  = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic sendPixel(input logic [7:0] hi, input logic [7:0] lo, input logic [3:0] addr,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      exp_write_t e;
      e.addr = addr; e.r = r; e.g = g; e.b = b;
      sb_queue.push_back(e);
      applyStimulus(hi, 1'b1);
      applyStimulus(lo, 1'b1);
   endtask

   task automatic sendDroppedPixel(input logic [7:0] hi, input logic [7:0] lo);
      applyStimulus(hi, 1'b1);
      applyStimulus(lo, 1'b1);
   endtask

   task automatic startFrame();
      vsync = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      vsync = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic endFrame();
      vsync = 1'b1;
      frame_done_exp++;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      rst = 1'b1; byte_en = 1'b0; vsync = 1'b0; href = 1'b0; cam_data = 8'h00;
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("reset_we", int'(write_enable), 0);
      checkOutput("reset_addr", int'(address_write), 0);
      checkOutput("reset_rgb", int'({data_w_R, data_w_G, data_w_B}), 0);
      checkOutput("reset_overflow", int'(overflow), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Bytes before any vsync falling edge are ignored
      sendDroppedPixel(8'hF8, 8'h00);

      // Red, green, blue, mid-grey in one frame
      startFrame();
      sendPixel(8'hF8, 8'h00, 4'd0, 8'hFF, 8'h00, 8'h00);
      sendPixel(8'h07, 8'hE0, 4'd1, 8'h00, 8'hFF, 8'h00);
      sendPixel(8'h00, 8'h1F, 4'd2, 8'h00, 8'h00, 8'hFF);
      sendPixel(8'h84, 8'h10, 4'd3, 8'h84, 8'h82, 8'h84);
      endFrame();
      checkOutput("addr_hold_after_end", int'(address_write), 3);

      // Overflow: 16 writes then dropped pixels
      startFrame();
      for (int i = 0; i < 16; i++) sendPixel(8'hF8, 8'h00, 4'(i), 8'hFF, 8'h00, 8'h00);
      checkOutput("overflow_at_full", int'(overflow), 0);
      sendDroppedPixel(8'h07, 8'hE0);
      checkOutput("overflow_after_17", int'(overflow), 1);
      sendDroppedPixel(8'h00, 8'h1F);
      checkOutput("overflow_sticky", int'(overflow), 1);
      checkOutput("addr_hold_full", int'(address_write), 15);
      endFrame();
      checkOutput("overflow_until_start", int'(overflow), 1);
      startFrame();
      checkOutput("overflow_cleared", int'(overflow), 0);

      // Half pixel discarded when href drops
      applyStimulus(8'hF8, 1'b1);
      applyStimulus(8'h55, 1'b0);
      sendPixel(8'h07, 8'hE0, 4'd0, 8'h00, 8'hFF, 8'h00);

      // Frame end with a hi byte in flight
      applyStimulus(8'hF8, 1'b1);
      endFrame();
      startFrame();
      sendPixel(8'h00, 8'h1F, 4'd0, 8'h00, 8'h00, 8'hFF);

      // vsync rising in the same cycle as a lo byte: no write
      applyStimulus(8'hF8, 1'b1);
      byte_en = 1'b1; cam_data = 8'h00; href = 1'b1; vsync = 1'b1;
      frame_done_exp++;
      @(posedge clk); #1;
      byte_en = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Reset mid-frame
      startFrame();
      for (int i = 0; i < 5; i++) sendPixel(8'h84, 8'h10, 4'(i), 8'h84, 8'h82, 8'h84);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midreset_addr", int'(address_write), 0);
      checkOutput("midreset_rgb", int'({data_w_R, data_w_G, data_w_B}), 0);
      checkOutput("midreset_we", int'(write_enable), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      sendDroppedPixel(8'hF8, 8'h00);
      sendDroppedPixel(8'h07, 8'hE0);
      startFrame();
      sendPixel(8'h07, 8'hE0, 4'd0, 8'h00, 8'hFF, 8'h00);
      sendPixel(8'hF8, 8'h00, 4'd1, 8'hFF, 8'h00, 8'h00);
      endFrame();

      for (int i = 0; i < 10 && sb_queue.size() != 0; i++) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", sb_queue.size(), 0);
      checkOutput("frame_done_count", frame_done_seen, frame_done_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
